ahb_apb_bridge_mslv: RTL and testbench

//  Parametrised AHB-Lite to APB bridge; successor to the single-slave BRIDGE_TOP.

---
 rtl/bridge_pkg.sv | 23 ++
 rtl/apb_addr_decode.sv | 35 +++
 rtl/ahb_apb_bridge_mslv.sv | 143 ++++++++++++++
 tb/tb_ahb_apb_bridge_mslv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: FSM states and AHB bus constants.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Base/size address decode: maps an AHB address onto one of NSLV equally sized APB slave regions.
module apb_addr_decode
    import bridge_pkg::*;
#(
    parameter int              AW        = 32,
    parameter int              NSLV      = 4,
    parameter int              SLV_AW    = 12,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000,
    parameter int              IW        = idx_width(NSLV)
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] sel,
    output logic [IW-1:0]   idx,
    output logic            miss
);

    localparam logic [AW:0] LIMIT = (AW+1)'(NSLV) << SLV_AW;

    logic [AW-1:0] off;
    logic          hit;

    // Unsigned wrap makes addresses below BASE_ADDR land far above LIMIT.
    assign off  = addr - BASE_ADDR;
    assign hit  = {1'b0, off} < LIMIT;
    assign idx  = off[SLV_AW +: IW];
    assign miss = !hit;

    always_comb begin
        sel = '0;
        for (int k = 0; k < NSLV; k++) begin
            sel[k] = hit && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite to multi-slave APB3 bridge with wait states, slave/decode errors and access timeout.
//  state  | meaning
//  IDLE   | ready for a new AHB transfer
//  LATCH  | AHB data phase, capture write data
//  SETUP  | APB setup phase, Pselx asserted
//  ACCESS | APB access phase, waiting for Pready
//  DONE   | OKAY response, can accept next transfer
//  ERR1   | first ERROR cycle, Hreadyout low
//  ERR2   | second ERROR cycle, can accept next transfer
module ahb_apb_bridge_mslv
    import bridge_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter int            NSLV      = 4,
    parameter int            SLV_AW    = 12,
    parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int            TIMEOUT   = 0
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic               Hwrite,
    input  logic [AW-1:0]      Haddr,
    input  logic [DW-1:0]      Hwdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic [DW-1:0]      Hrdata,
    output logic [NSLV-1:0]    Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [AW-1:0]      Paddr,
    output logic [DW-1:0]      Pwdata,
    input  logic [NSLV*DW-1:0] Prdata,
    input  logic [NSLV-1:0]    Pready,
    input  logic [NSLV-1:0]    Pslverr
);

    localparam int IW = idx_width(NSLV);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [NSLV-1:0] dec_sel, sel_q;
    logic [IW-1:0]   dec_idx, idx_q;
    logic            dec_miss;
    logic            accept;
    logic            prdy, perr;
    logic [DW-1:0]   prd;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;

    apb_addr_decode #(
        .AW        (AW),
        .NSLV      (NSLV),
        .SLV_AW    (SLV_AW),
        .BASE_ADDR (BASE_ADDR),
        .IW        (IW)
    ) u_dec (
        .addr (Haddr),
        .sel  (dec_sel),
        .idx  (dec_idx),
        .miss (dec_miss)
    );

    // Hreadyout is high exactly in IDLE/DONE/ERR2, so it doubles as the accept window.
    assign accept = Hreadyin && Hreadyout &&
                    ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        prdy = 1'b0;
        perr = 1'b0;
        prd  = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == IW'(k)) begin
                prdy = Pready[k];
                perr = Pslverr[k];
                prd  = Prdata[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) state_d = dec_miss ? ST_ERR1 : ST_LATCH;
                else        state_d = ST_IDLE;
            end
            ST_LATCH:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (prdy)         state_d = perr ? ST_ERR1 : ST_DONE;
                else if (tmo_hit) state_d = ST_ERR1;
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
            Hrdata    <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            tmo_cnt   <= '0;
        end else begin
            Hreadyout <= (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
            Hresp     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            Pselx     <= ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? sel_q : '0;
            Penable   <= (state_d == ST_ACCESS);

            if (accept) begin
                Paddr  <= Haddr;
                Pwrite <= Hwrite;
                sel_q  <= dec_sel;
                idx_q  <= dec_idx;
            end

            if ((state_q == ST_LATCH) && Pwrite) Pwdata <= Hwdata;

            if ((state_q == ST_ACCESS) && prdy && !perr && !Pwrite) Hrdata <= prd;

            if (state_q == ST_SETUP)       tmo_cnt <= '0;
            else if (state_q == ST_ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Directed bench for the AHB-APB bridge: 4 slaves at 0x8000_0000, 4 KiB each, timeout of 8.
module tb_ahb_apb_bridge_mslv;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NSLV = 4;

    logic               Hclk;
    logic               Hreset;
    logic               Hreadyin;
    logic [1:0]         Htrans;
    logic               Hwrite;
    logic [AW-1:0]      Haddr;
    logic [DW-1:0]      Hwdata;
    logic               Hreadyout;
    logic [1:0]         Hresp;
    logic [DW-1:0]      Hrdata;
    logic [NSLV-1:0]    Pselx;
    logic               Penable;
    logic               Pwrite;
    logic [AW-1:0]      Paddr;
    logic [DW-1:0]      Pwdata;
    logic [NSLV*DW-1:0] Prdata;
    logic [NSLV-1:0]    Pready;
    logic [NSLV-1:0]    Pslverr;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    ahb_apb_bridge_mslv #(
        .DW        (DW),
        .AW        (AW),
        .NSLV      (NSLV),
        .SLV_AW    (12),
        .BASE_ADDR (32'h8000_0000),
        .TIMEOUT   (8)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic wr, input logic [31:0] addr);
        Htrans = 2'b10;
        Hwrite = wr;
        Haddr  = addr;
    endtask

    initial begin
        Hreset   = 1'b1;
        Hreadyin = 1'b1;
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Haddr    = '0;
        Hwdata   = '0;
        Prdata   = '0;
        Pready   = 4'b1111;
        Pslverr  = 4'b0000;
        tick();
        tick();
        chk("rst_hreadyout", Hreadyout, 1);
        chk("rst_hresp",     Hresp,     0);
        chk("rst_hrdata",    Hrdata,    0);
        chk("rst_pselx",     Pselx,     0);
        chk("rst_penable",   Penable,   0);
        chk("rst_paddr",     Paddr,     0);
        chk("rst_pwdata",    Pwdata,    0);
        chk("rst_pwrite",    Pwrite,    0);
        Hreset = 1'b0;
        tick();

        // single write to slave 1, zero-wait
        start(1'b1, 32'h8000_1004);
        tick();                                  // edge 0 -> LATCH
        Htrans = 2'b00;
        Hwdata = 32'hA5A5_0001;
        chk("wr_stall0", Hreadyout, 0);
        tick();                                  // edge 1 -> SETUP
        chk("wr_setup_pselx",   Pselx,   4'b0010);
        chk("wr_setup_penable", Penable, 0);
        chk("wr_paddr",         Paddr,   32'h8000_1004);
        chk("wr_pwdata",        Pwdata,  32'hA5A5_0001);
        chk("wr_pwrite",        Pwrite,  1);
        tick();                                  // edge 2 -> ACCESS
        chk("wr_access_penable", Penable, 1);
        tick();                                  // edge 3 -> DONE, seen at edge 4
        chk("wr_done_ready", Hreadyout, 1);
        chk("wr_done_resp",  Hresp,     0);
        chk("wr_done_pselx", Pselx,     0);
        chk("wr_hrdata",     Hrdata,    0);
        tick();

        // read slave 3, two wait states; slave 0 error must be ignored
        Prdata[0*32 +: 32] = 32'h1111_1111;
        Prdata[2*32 +: 32] = 32'h1234_5678;
        Prdata[3*32 +: 32] = 32'hDEAD_BEEF;
        Pready  = 4'b0111;
        Pslverr = 4'b0001;
        start(1'b0, 32'h8000_3010);
        tick();                                  // edge 0
        Htrans = 2'b00;
        tick();                                  // edge 1
        chk("rd_pselx", Pselx, 4'b1000);
        tick();                                  // edge 2
        tick();                                  // edge 3, Pready low
        tick();                                  // edge 4, Pready low
        chk("rd_wait_ready",   Hreadyout, 0);
        chk("rd_wait_penable", Penable,   1);
        chk("rd_wait_hrdata",  Hrdata,    0);
        Pready = 4'b1111;
        tick();                                  // edge 5 -> DONE, seen at edge 6
        chk("rd_done_ready",  Hreadyout, 1);
        chk("rd_done_resp",   Hresp,     0);
        chk("rd_hrdata",      Hrdata,    32'hDEAD_BEEF);
        tick();

        // slave error on slave 2 read
        Pslverr = 4'b0100;
        start(1'b0, 32'h8000_2000);
        tick();
        Htrans = 2'b00;
        tick();
        tick();
        tick();                                  // -> ERR1
        chk("slverr_e1_ready", Hreadyout, 0);
        chk("slverr_e1_resp",  Hresp,     2'b01);
        chk("slverr_e1_pselx", Pselx,     0);
        tick();                                  // -> ERR2
        chk("slverr_e2_ready", Hreadyout, 1);
        chk("slverr_e2_resp",  Hresp,     2'b01);
        chk("slverr_hrdata",   Hrdata,    32'hDEAD_BEEF);
        tick();
        chk("slverr_idle_resp", Hresp, 0);
        Pslverr = 4'b0000;

        // decode miss below base, then above top accepted straight from ERR2
        start(1'b0, 32'h7FFF_FFFC);
        tick();
        chk("miss_lo_ready", Hreadyout, 0);
        chk("miss_lo_resp",  Hresp,     2'b01);
        chk("miss_lo_pselx", Pselx,     0);
        Htrans = 2'b00;
        tick();
        chk("miss_lo_e2_ready", Hreadyout, 1);
        chk("miss_lo_e2_resp",  Hresp,     2'b01);
        start(1'b1, 32'h8000_4000);
        tick();
        chk("miss_hi_ready", Hreadyout, 0);
        chk("miss_hi_resp",  Hresp,     2'b01);
        chk("miss_hi_pselx", Pselx,     0);
        Htrans = 2'b00;
        tick();
        chk("miss_hi_e2_pselx", Pselx, 0);
        tick();

        // Hreadyin low and BUSY are not accepted
        Hreadyin = 1'b0;
        start(1'b1, 32'h8000_0000);
        tick();
        Hreadyin = 1'b1;
        Htrans   = 2'b01;
        tick();
        Htrans = 2'b00;
        tick();
        chk("ignore_ready", Hreadyout, 1);
        chk("ignore_pselx", Pselx,     0);

        // timeout: slave 1 never ready
        Pready = 4'b1101;
        start(1'b0, 32'h8000_1000);
        tick();                                  // edge 0
        Htrans = 2'b00;
        tick();                                  // edge 1 SETUP
        tick();                                  // edge 2 ACCESS
        for (int i = 0; i < 7; i++) tick();      // edges 3..9
        chk("tmo_still_penable", Penable, 1);
        tick();                                  // edge 10 -> ERR1
        chk("tmo_penable", Penable,   0);
        chk("tmo_pselx",   Pselx,     0);
        chk("tmo_resp",    Hresp,     2'b01);
        chk("tmo_ready",   Hreadyout, 0);
        chk("tmo_hrdata",  Hrdata,    32'hDEAD_BEEF);
        tick();
        tick();
        Pready = 4'b1111;

        // back-to-back: write slave 0, next read accepted in DONE
        start(1'b1, 32'h8000_0008);
        tick();
        Htrans = 2'b00;
        Hwdata = 32'h0000_00AA;
        tick();
        tick();
        tick();                                  // DONE
        chk("b2b_done_ready", Hreadyout, 1);
        start(1'b0, 32'h8000_2004);
        tick();                                  // straight to LATCH
        chk("b2b_no_idle", Hreadyout, 0);
        chk("b2b_paddr",   Paddr,     32'h8000_2004);
        Htrans = 2'b00;
        tick();
        chk("b2b_pselx",  Pselx,  4'b0100);
        chk("b2b_pwrite", Pwrite, 0);
        chk("b2b_pwdata", Pwdata, 32'h0000_00AA);
        tick();
        tick();
        chk("b2b_hrdata", Hrdata,    32'h1234_5678);
        chk("b2b_ready",  Hreadyout, 1);
        tick();

        // reset in the middle of ACCESS
        Pready = 4'b0000;
        start(1'b1, 32'h8000_3000);
        tick();
        Htrans = 2'b00;
        Hwdata = 32'h5555_AAAA;
        tick();
        tick();
        chk("mid_penable", Penable, 1);
        Hreset = 1'b1;
        tick();
        chk("mid_rst_pselx",   Pselx,     0);
        chk("mid_rst_penable", Penable,   0);
        chk("mid_rst_ready",   Hreadyout, 1);
        chk("mid_rst_resp",    Hresp,     0);
        chk("mid_rst_hrdata",  Hrdata,    0);
        chk("mid_rst_paddr",   Paddr,     0);
        chk("mid_rst_pwdata",  Pwdata,    0);
        Hreset = 1'b0;
        Pready = 4'b1111;
        tick();
        chk("post_rst_pselx", Pselx, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
